ram_stream_writer: RTL and testbench



---
 rtl/ram_stream_writer_pkg.sv | 17 +
 rtl/ram_stream_fifo.sv | 61 ++++++
 rtl/ram_stream_writer.sv | 146 ++++++++++++++
 tb/tb_ram_stream_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_writer_pkg.sv
// Shared types and handshake helper for the RAM stream writer slice.
package ram_stream_writer_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } state_e;

  function automatic logic xfer(input logic trig, input logic rdy);
    return trig && rdy;
  endfunction

endpackage

// File: rtl/ram_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with registered empty/full flags.
// empty_next exposes the flag that will be registered at the next edge.
module ram_stream_fifo
  import ram_stream_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty_next
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage is flushed by the pointers alone, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head       = mem_q[rd_ptr_q];
  assign full       = full_q;
  assign empty_next = empty_d;

endmodule

// File: rtl/ram_stream_writer.sv
// Buffers a word stream and writes it to RAMController as a run of
// consecutive BlockSize-word blocks.
module ram_stream_writer
  import ram_stream_writer_pkg::*;
#(
  parameter int unsigned BlockWidth = 21,
  parameter int unsigned BlockSize  = 16,
  parameter int unsigned CountWidth = 6,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_trigger,
  output logic                  start_ready,
  input  logic [BlockWidth-1:0] start_block,
  input  logic [CountWidth-1:0] start_count,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  cmd_ready,
  output logic                  cmd_trigger,
  output logic [BlockWidth-1:0] cmd_block,
  output logic                  cmd_write,
  input  logic                  data_ready,
  output logic                  data_trigger,
  output logic [DATA_W-1:0]     data_write
);

  localparam int unsigned IdxW = $clog2(BlockSize);

  state_e                state_q, state_d;
  logic [BlockWidth-1:0] block_q, block_d;
  logic [CountWidth-1:0] remaining_q, remaining_d;
  logic [IdxW-1:0]       word_idx_q, word_idx_d;
  logic                  cmd_trigger_q, cmd_trigger_d;
  logic                  cmd_write_q, cmd_write_d;
  logic                  data_trigger_q, data_trigger_d;
  logic                  done_q, done_d;
  logic                  start_ready_q, start_ready_d;
  logic                  fifo_full, fifo_empty_next;

  ram_stream_fifo #(.DEPTH(FifoDepth)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .pop        (data_trigger_q && data_ready),
    .wdata      (in_data),
    .head       (data_write),
    .full       (fifo_full),
    .empty_next (fifo_empty_next)
  );

  always_comb begin
    state_d       = state_q;
    block_d       = block_q;
    remaining_d   = remaining_q;
    word_idx_d    = word_idx_q;
    cmd_trigger_d = cmd_trigger_q;
    cmd_write_d   = cmd_write_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer(start_trigger, start_ready_q)) begin
          block_d     = start_block;
          remaining_d = start_count;
          if (start_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d       = ST_CMD;
            cmd_trigger_d = 1'b1;
            cmd_write_d   = 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (xfer(cmd_trigger_q, cmd_ready)) begin
          cmd_trigger_d = 1'b0;
          cmd_write_d   = 1'b0;
          word_idx_d    = '0;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer(data_trigger_q, data_ready)) begin
          word_idx_d = word_idx_q + IdxW'(1);
          if (word_idx_q == IdxW'(BlockSize - 1)) begin
            block_d     = block_q + BlockWidth'(1);
            remaining_d = remaining_q - CountWidth'(1);
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Controller raises cmd_ready again once the block write has landed.
        if (cmd_ready) begin
          if (remaining_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d       = ST_CMD;
            cmd_trigger_d = 1'b1;
            cmd_write_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered from next-cycle emptiness so it lines up with the FIFO head.
    data_trigger_d = (state_d == ST_DATA) && !fifo_empty_next;
    start_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      block_q        <= '0;
      remaining_q    <= '0;
      word_idx_q     <= '0;
      cmd_trigger_q  <= 1'b0;
      cmd_write_q    <= 1'b0;
      data_trigger_q <= 1'b0;
      done_q         <= 1'b0;
      start_ready_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      block_q        <= block_d;
      remaining_q    <= remaining_d;
      word_idx_q     <= word_idx_d;
      cmd_trigger_q  <= cmd_trigger_d;
      cmd_write_q    <= cmd_write_d;
      data_trigger_q <= data_trigger_d;
      done_q         <= done_d;
      start_ready_q  <= start_ready_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign done         = done_q;
  assign in_ready     = !fifo_full;
  assign cmd_trigger  = cmd_trigger_q;
  assign cmd_block    = block_q;
  assign cmd_write    = cmd_write_q;
  assign data_trigger = data_trigger_q;

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed bench for ram_stream_writer: reset, runs, wrap, zero count,
// slow stream, FIFO full and mid-run reset.
module tb_ram_stream_writer;

  localparam int BW = 21;
  localparam int BS = 16;
  localparam int CW = 6;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_trigger = 1'b0;
  logic          start_ready;
  logic [BW-1:0] start_block = '0;
  logic [CW-1:0] start_count = '0;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          cmd_ready = 1'b0;
  logic          cmd_trigger;
  logic [BW-1:0] cmd_block;
  logic          cmd_write;
  logic          data_ready = 1'b0;
  logic          data_trigger;
  logic [15:0]   data_write;

  always #5 clk = ~clk;

  ram_stream_writer #(
    .BlockWidth(BW), .BlockSize(BS), .CountWidth(CW), .FifoDepth(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .start_trigger(start_trigger), .start_ready(start_ready),
    .start_block(start_block), .start_count(start_count), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmd_ready(cmd_ready), .cmd_trigger(cmd_trigger), .cmd_block(cmd_block),
    .cmd_write(cmd_write),
    .data_ready(data_ready), .data_trigger(data_trigger), .data_write(data_write)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int in_cnt = 0;
  int cmd_write_bad = 0;
  int gap = 0;
  logic [31:0] cmd_log[$];
  logic [31:0] data_log[$];
  logic [15:0] src_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transfer monitor: sampled mid-cycle, each hit is a transfer at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_trigger && cmd_ready) begin
          cmd_log.push_back(32'(cmd_block));
          if (cmd_write !== 1'b1) cmd_write_bad++;
        end
        if (data_trigger && data_ready) data_log.push_back(32'(data_write));
        if (done) done_cnt++;
        if (in_valid && in_ready) in_cnt++;
      end
    end
  end

  // Stream source: presents src_q in order, idling 'gap' cycles after each accept.
  initial begin
    logic acc;
    int   gap_cnt;
    in_valid = 1'b0;
    in_data  = '0;
    gap_cnt  = 0;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && !rst;
      @(posedge clk);
      #1;
      if (acc) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        gap_cnt = gap;
      end else if (gap_cnt > 0 && !in_valid) begin
        gap_cnt--;
      end
      if (src_q.size() > 0 && gap_cnt == 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(16'(base + i));
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    data_log.delete();
    cmd_write_bad = 0;
  endtask

  task automatic run_start(input logic [BW-1:0] blk, input logic [CW-1:0] cnt);
    for (int i = 0; i < 20 && !start_ready; i++) cyc(1);
    chk("start_ready_before_start", 32'(start_ready), 32'd1);
    start_block   = blk;
    start_count   = cnt;
    start_trigger = 1'b1;
    cyc(1);
    start_trigger = 1'b0;
  endtask

  task automatic run_and_wait(input string tag, input logic [BW-1:0] blk,
                              input logic [CW-1:0] cnt, input int budget);
    int d0;
    d0 = done_cnt;
    run_start(blk, cnt);
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc(1);
    cyc(3);
    chk(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    chk({tag, "_count"}, 32'(data_log.size()), 32'(n));
    for (int i = 0; i < n && i < data_log.size(); i++)
      chk(tag, data_log[i], 32'(16'(base + i)));
  endtask

  initial begin
    int d0;
    // Reset state
    cyc(2);
    rst = 1'b0;
    chk("rst_start_ready", 32'(start_ready), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cmd_trigger", 32'(cmd_trigger), 32'd0);
    chk("rst_data_trigger", 32'(data_trigger), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_write", 32'(cmd_write), 32'd0);
    chk("rst_cmd_block", 32'(cmd_block), 32'd0);
    cyc(1);
    chk("idle_start_ready", 32'(start_ready), 32'd1);

    // Preload with controller stalled: exactly FifoDepth words accepted
    clear_logs();
    load(0, 16);
    cyc(14);
    chk("full_in_cnt", 32'(in_cnt), 32'(FD));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_data_trigger", 32'(data_trigger), 32'd0);

    // Single block at 0x10
    cmd_ready  = 1'b1;
    data_ready = 1'b1;
    run_and_wait("t1_done", 21'h10, 6'd1, 200);
    chk("t1_cmd_count", 32'(cmd_log.size()), 32'd1);
    if (cmd_log.size() > 0) chk("t1_cmd_block", cmd_log[0], 32'h10);
    chk("t1_cmd_write", 32'(cmd_write_bad), 32'd0);
    check_words("t1_word", 0, 16);
    chk("t1_in_cnt", 32'(in_cnt), 32'd16);

    // Two blocks wrapping the block address
    clear_logs();
    load(16'h1000, 32);
    run_and_wait("t2_done", 21'h1FFFFF, 6'd2, 300);
    chk("t2_cmd_count", 32'(cmd_log.size()), 32'd2);
    if (cmd_log.size() > 1) begin
      chk("t2_cmd_block0", cmd_log[0], 32'h1FFFFF);
      chk("t2_cmd_block1", cmd_log[1], 32'h0);
    end
    chk("t2_cmd_write", 32'(cmd_write_bad), 32'd0);
    check_words("t2_word", 16'h1000, 32);

    // Zero count: done next cycle, no command
    clear_logs();
    d0 = done_cnt;
    run_start(21'h5, 6'd0);
    chk("t3_done_pulse", 32'(done), 32'd1);
    chk("t3_cmd_trigger", 32'(cmd_trigger), 32'd0);
    chk("t3_start_ready", 32'(start_ready), 32'd1);
    cyc(1);
    chk("t3_done_low", 32'(done), 32'd0);
    cyc(3);
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t3_no_cmd", 32'(cmd_log.size()), 32'd0);

    // Slow stream, one word per 5 cycles
    clear_logs();
    gap = 4;
    load(16'h100, 16);
    run_and_wait("t4_done", 21'h20, 6'd1, 400);
    chk("t4_cmd_count", 32'(cmd_log.size()), 32'd1);
    check_words("t4_word", 16'h100, 16);
    gap = 0;

    // Reset in Data with word 7 pending
    clear_logs();
    load(16'h300, 16);
    run_start(21'h40, 6'd1);
    for (int i = 0; i < 200 && data_log.size() < 7; i++) cyc(1);
    chk("t6_words_before_rst", 32'(data_log.size()), 32'd7);
    rst = 1'b1;
    src_q.delete();
    cyc(1);
    chk("t6_cmd_trigger", 32'(cmd_trigger), 32'd0);
    chk("t6_data_trigger", 32'(data_trigger), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_start_ready_rst", 32'(start_ready), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("t6_start_ready", 32'(start_ready), 32'd1);
    cyc(2);
    clear_logs();
    load(16'h400, 16);
    run_and_wait("t6_rerun_done", 21'h50, 6'd1, 200);
    chk("t6_cmd_count", 32'(cmd_log.size()), 32'd1);
    if (cmd_log.size() > 0) chk("t6_cmd_block", cmd_log[0], 32'h50);
    check_words("t6_word", 16'h400, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
